tdm_demux_deserializer: RTL and testbench
=========================================

// Module: tdm_demux_deserializer
// PURPOSE
//  Receive end of a time-division link whose transmit end is a 4:1 select mux (slot index A, data I).
//  Collects N_CH consecutive serial slots into one parallel frame.
//  Presents the frame on Y with a one-cycle Y_valid strobe.
//  Sits downstream of the mux-based serializer; drives the 2-to-4 decoder / compare logic.
// PARAMETERS
//  N_CH  4  slots (channels) per frame, >=2
//  W     1  data width of one slot, bits
// PORTS
//  clk      in   1         single clock, all state on rising edge
//  rst      in   1         asynchronous, active-high reset
//  E        in   1         inhibit, active-high (same sense as the mux enable): 1 = receiver disabled
//  I        in   W         serial slot data
//  I_valid  in   1         I carries a slot this cycle
//  sync     in   1         qualified by I_valid: this slot is slot 0 of a new frame
//  Y        out  N_CH*W    frame, range [0:N_CH*W-1]; slot k at Y[k*W +: W]
//  Y_valid  out  1         one-cycle strobe, Y updated this cycle
//  A        out  SW        slot index expected next; SW = $clog2(N_SLOTS)
//  err      out  1         one-cycle strobe: partial frame discarded
// BEHAVIOUR
//  Reset: A=0, Y=0, Y_valid=0, err=0, shadow frame=0. No clk edge needed.
//  Accept: I_valid & ~E. Shadow slot A <= I; A <= A+1; A wraps N_SLOTS-1 -> 0.
//  Frame close: accept at A==N_SLOTS-1. Next edge: Y <= {shadow, I}, Y_valid=1 for one cycle.
//  Latency: last slot in -> Y/Y_valid registered 1 cycle later. Y holds until the next frame close.
//  Back-to-back frames need no gap. Y_valid can assert every N_SLOTS cycles.
//  sync & accept at A!=0: slot written as slot 0, A <= 1, err=1 next cycle, partial frame dropped.
//  sync & accept at A==0: normal accept, no err. sync without I_valid: ignored.
//  E=1: no accept, A <= 0, shadow <= 0, Y <= 0, Y_valid=0, err=0 (frame aborted, outputs forced 0).
//  E falling: reception restarts at slot 0.
//  rst mid-frame: all state cleared immediately; partial frame lost, no err.
//  States: IDLE (A==0, no partial frame) / FILL (0<A). IDLE->FILL on accept.
//  FILL->IDLE on frame close or E. sync in FILL -> FILL at A=1 with err.
// CONFIGURATION
//  PARITY_CHECK_EN undefined: N_SLOTS = N_CH.
//  PARITY_CHECK_EN defined: N_SLOTS = N_CH+1. Extra final slot carries the even parity of the frame.
//  Even parity: XOR of all N_CH*W data bits, placed in the LSB of the extra slot; its other bits are ignored.
//  On mismatch: Y not updated, Y_valid=0, err=1 at the cycle Y_valid would have been.
//  On match: behaviour identical to the undefined case, one slot later.
// STRUCTURE
//  Package tdm_pkg: TDM_N_CH_DEF, TDM_W_DEF, function slot_w(n)=$clog2(n), state enum {IDLE, FILL}.
//  Sub-module tdm_slot_counter:
//   - inputs: clk, rst, clr (E), load1 (sync), inc (accept)
//   - outputs: A, last
//   - priority: clr > load1 > inc.
//  Top: shadow register file, frame register, strobes, optional parity checker.
// TESTING (N_CH=4, W=1 unless noted)
//  1. rst=1 at t=0, no clock -> Y=4'b0000, A=0, Y_valid=0, err=0.
//  2. E=0, sync on first slot, I=1,0,1,1 on 4 consecutive valid cycles
//     -> next cycle Y=4'b1011 ([0:3]), Y_valid=1 for exactly 1 cycle, A=0.
//  3. Two frames back-to-back, 1000 then 0001, no gap -> Y_valid pulses 4 cycles apart.
//     Y=1000, then Y=0001.
//  4. After 2 slots (A=2), sync with I=1 -> err=1 one cycle, A=1.
//     Next 3 slots 0,0,1 -> Y=4'b1001.
//  5. E=1 at A=3 with Y=1011 -> next edge Y=0000, A=0, no Y_valid.
//     E=0, full frame 0110 -> Y=0110.
//  6. PARITY_CHECK_EN, data 1,1,1,0 + parity 1 -> Y=1110, Y_valid.
//     Same data + parity 0 -> err=1, Y stays 1110.

Source files
------------

// File: rtl/tdm_demux_deserializer_pkg.sv
// Shared types and defaults for the TDM receive deserializer.
// PARITY_CHECK_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

  localparam int TDM_N_CH_DEF = 4;
  localparam int TDM_W_DEF    = 1;

`ifdef PARITY_CHECK_EN
  localparam int TDM_PAR = 1;
`else
  localparam int TDM_PAR = 0;
`endif

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  function automatic int slot_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_deserializer_if.sv
// Serial slot input and parallel frame output bundle of the receiver.
// The slot index width includes the parity slot when PARITY_CHECK_EN is set.
interface tdm_demux_deserializer_if
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEF,
  parameter int W    = TDM_W_DEF
);

  localparam int SW = slot_w(N_CH + TDM_PAR);

  logic                E;
  logic [W-1:0]        I;
  logic                I_valid;
  logic                sync;
  logic [0:N_CH*W-1]   Y;
  logic                Y_valid;
  logic [SW-1:0]       A;
  logic                err;

  modport master (
    output E, I, I_valid, sync,
    input  Y, Y_valid, A, err
  );

  modport slave (
    input  E, I, I_valid, sync,
    output Y, Y_valid, A, err
  );

endinterface

// File: rtl/tdm_demux_deserializer_slot_counter.sv
// Slot index counter: clear beats resync-to-1 beats increment.
// Wraps from N_SLOTS-1 back to 0.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int N_SLOTS = TDM_N_CH_DEF,
  parameter int SW      = slot_w(N_SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] A,
  output logic          last
);

  assign last = (A == SW'(N_SLOTS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A <= '0;
    end else if (clr) begin
      A <= '0;
    end else if (load1) begin
      A <= SW'(1);
    end else if (inc) begin
      A <= last ? '0 : A + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_deserializer.sv
// TDM receiver: gathers N_CH serial slots into one registered frame.
// With PARITY_CHECK_EN an extra slot carries even parity of the frame.
module tdm_demux_deserializer
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEF,
  parameter int W    = TDM_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  tdm_demux_deserializer_if.slave bus
);

  localparam int NS = N_CH + TDM_PAR;
  localparam int SW = slot_w(NS);

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     a;
  logic [SW-1:0]     idx;
  logic              last;
  logic              accept;
  logic              resync;
  logic              close;
  logic              par_ok;
  logic [0:N_CH*W-1] sh;
  logic [0:N_CH*W-1] frame;

  assign accept = bus.I_valid & ~bus.E;
  assign resync = accept & bus.sync & (state == FILL);
  assign close  = accept & last & ~resync;
  assign idx    = resync ? '0 : a;
  assign bus.A  = a;

  tdm_slot_counter #(
    .N_SLOTS (NS),
    .SW      (SW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.E),
    .load1 (accept & bus.sync),
    .inc   (accept),
    .A     (a),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.E || close) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (bus.E) begin
      sh <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_CH; k++) begin
        if (idx == SW'(k)) begin
          sh[k*W +: W] <= bus.I;
        end
      end
    end
  end

  // Without parity the closing slot is live data, not yet in the shadow.
  always_comb begin
    frame = sh;
`ifndef PARITY_CHECK_EN
    frame[(N_CH-1)*W +: W] = bus.I;
`endif
  end

`ifdef PARITY_CHECK_EN
  assign par_ok = ((^sh) == bus.I[0]);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Y       <= '0;
      bus.Y_valid <= 1'b0;
      bus.err     <= 1'b0;
    end else if (bus.E) begin
      bus.Y       <= '0;
      bus.Y_valid <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.Y_valid <= 1'b0;
      bus.err     <= resync;
      if (close) begin
        if (par_ok) begin
          bus.Y       <= frame;
          bus.Y_valid <= 1'b1;
        end else begin
          bus.err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_deserializer.sv
// Bench for tdm_demux_deserializer: directed frames plus random traffic
// checked against a queue-based frame model.
module tb_tdm_demux_deserializer;

  localparam int N_CH = 4;
  localparam int W    = 1;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NS = N_CH + (PAR ? 1 : 0);

  logic clk = 1'b0;
  logic rst = 1'b0;

  tdm_demux_deserializer_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_demux_deserializer #(.N_CH(N_CH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [W-1:0]      q[$];
  logic [0:N_CH*W-1] m_y;
  logic              m_yv;
  logic              m_err;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_y   = '0;
    m_yv  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic v,
                            input logic s, input logic [W-1:0] i);
    logic p;
    m_yv  = 1'b0;
    m_err = 1'b0;
    if (e) begin
      q.delete();
      m_y = '0;
    end else if (v) begin
      if (s && q.size() != 0) begin
        q.delete();
        m_err = 1'b1;
      end
      q.push_back(i);
      if (q.size() == NS) begin
        p = 1'b0;
        for (int k = 0; k < N_CH; k++) p = p ^ (^q[k]);
        if (!PAR || p == q[NS-1][0]) begin
          for (int k = 0; k < N_CH; k++) m_y[k*W +: W] = q[k];
          m_yv = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        q.delete();
      end
    end
  endtask

  task automatic check_all();
    check("y",   64'(bus.Y),       64'(m_y));
    check("yv",  64'(bus.Y_valid), 64'(m_yv));
    check("err", 64'(bus.err),     64'(m_err));
    check("a",   64'(bus.A),       64'(q.size()));
  endtask

  task automatic drive(input logic e, input logic v,
                       input logic s, input logic [W-1:0] i);
    bus.E       = e;
    bus.I_valid = v;
    bus.sync    = s;
    bus.I       = i;
    @(posedge clk);
    model_step(e, v, s, i);
    #1;
    check_all();
  endtask

  task automatic send(input logic [0:3] d);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, k == 0, d[k]);
  endtask

  initial begin
    bus.E = 1'b0; bus.I = '0; bus.I_valid = 1'b0; bus.sync = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_y",   64'(bus.Y),       64'd0);
    check("rst_a",   64'(bus.A),       64'd0);
    check("rst_yv",  64'(bus.Y_valid), 64'd0);
    check("rst_err", 64'(bus.err),     64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(4'b1011);
`ifndef PARITY_CHECK_EN
    check("t2_y",  64'(bus.Y),       64'b1011);
    check("t2_yv", 64'(bus.Y_valid), 64'd1);
    check("t2_a",  64'(bus.A),       64'd0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_yv_off", 64'(bus.Y_valid), 64'd0);

    send(4'b1000);
`ifndef PARITY_CHECK_EN
    check("t3_y0", 64'(bus.Y), 64'b1000);
`endif
    send(4'b0001);
`ifndef PARITY_CHECK_EN
    check("t3_y1",  64'(bus.Y),       64'b0001);
    check("t3_yv1", 64'(bus.Y_valid), 64'd1);
`endif

    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_err", 64'(bus.err), 64'd1);
    check("t4_a",   64'(bus.A),   64'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
`ifndef PARITY_CHECK_EN
    check("t4_y", 64'(bus.Y), 64'b1001);
`endif

    send(4'b1011);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, k == 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_y", 64'(bus.Y),       64'd0);
    check("t5_a", 64'(bus.A),       64'd0);
    check("t5_v", 64'(bus.Y_valid), 64'd0);
    send(4'b0110);
`ifndef PARITY_CHECK_EN
    check("t5_y2", 64'(bus.Y), 64'b0110);
`endif

`ifdef PARITY_CHECK_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send(4'b1110);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_y",  64'(bus.Y),       64'b1110);
    check("t6_yv", 64'(bus.Y_valid), 64'd1);
    send(4'b1110);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_err", 64'(bus.err), 64'd1);
    check("t6_y2",  64'(bus.Y),   64'b1110);
`endif

    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mrst_a", 64'(bus.A), 64'd0);
    check("mrst_y", 64'(bus.Y), 64'd0);
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
